// File: rtl/ibus_mem_responder.sv
// Instruction-bus responder backed by a preloadable word store, used to close the fetch-stage loop.
// Optional IBUS_RAND_STALL_EN adds 0..3 LFSR-driven extra wait cycles per request.
package ibus_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

module ibus_mem_responder
    import ibus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int          LATENCY     = 2,
    localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  ibus_req_t        ireq,
    output ibus_resp_t       iresp,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [31:0]      load_data,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_addr;
    logic [31:0] r_data;
    logic        r_data_ok;
    logic        r_busy;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [4:0]  w_stall;
    logic [4:0]  w_wait_cycles;
    logic [63:0] w_rd_addr;
    logic [61:0] w_word_off;
    logic        w_in_range;
    logic        w_aligned;
    logic        w_hit;
    logic [31:0] w_rd_word;
    logic        w_accept;
    logic        w_enter_resp;

`ifdef IBUS_RAND_STALL_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; free-running so stall patterns vary between requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_stall = {3'b000, r_lfsr[1:0]};
`else
    assign w_stall = 5'd0;
`endif

    // WAIT cycles still to spend after acceptance; zero means the accept edge goes straight to RESP.
    assign w_wait_cycles = 5'(LATENCY - 1) + w_stall;

    assign w_accept     = (r_state == S_IDLE) && ireq.valid;
    assign w_enter_resp = (w_accept && (w_wait_cycles == 5'd0)) ||
                          ((r_state == S_WAIT) && (r_cnt == 5'd1));

    // In IDLE the only path to RESP is the LATENCY=1 shortcut, which must use the live address.
    assign w_rd_addr  = (r_state == S_IDLE) ? ireq.addr : r_addr;
    assign w_word_off = w_rd_addr[63:2] - BASE_ADDR[63:2];
    assign w_in_range = (w_rd_addr >= BASE_ADDR) && (w_word_off < 62'(DEPTH_WORDS));
    assign w_aligned  = (w_rd_addr[1:0] == 2'b00);
    assign w_hit      = w_in_range && w_aligned;
    assign w_rd_word  = r_mem[w_word_off[IDX_W-1:0]];

    // Store contents survive reset; the read happens on the same edge, so a colliding load returns the old word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            r_mem[load_idx] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_addr    <= 64'd0;
            r_data    <= 32'd0;
            r_data_ok <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_data_ok <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ireq.valid) begin
                        r_addr <= ireq.addr;
                        r_busy <= 1'b1;
                        if (w_wait_cycles == 5'd0) begin
                            r_state <= S_RESP;
                            r_cnt   <= 5'd0;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= w_wait_cycles;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 5'd1) begin
                        r_state <= S_RESP;
                        r_cnt   <= 5'd0;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_enter_resp) begin
                r_data_ok <= 1'b1;
                r_data    <= w_hit ? w_rd_word : 32'h0000_0000;
                if (!w_hit) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // addr_ok is the only combinational response; masking with reset hides a held valid during reset.
    always_comb begin
        iresp         = '0;
        iresp.addr_ok = reset && (r_state == S_IDLE) && ireq.valid;
        iresp.data_ok = r_data_ok;
        iresp.data    = r_data;
    end

    assign busy = r_busy;
    assign err  = r_err;

endmodule

// File: tb/tb_ibus_mem_responder.sv
// Scoreboard bench for ibus_mem_responder: expected words are queued at request time
// and popped by a monitor whenever data_ok pulses.
module tb_ibus_mem_responder;
    import ibus_pkg::*;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;
`ifdef IBUS_RAND_STALL_EN
    localparam int MAXSTALL = 3;
`else
    localparam int MAXSTALL = 0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        load_en;
    logic [9:0]  load_idx;
    logic [31:0] load_data;
    logic        busy;
    logic        err;

    int          checks;
    int          failures;
    logic [31:0] modelMem [DEPTH];
    logic        modelErr;
    exp_t        sbQ [$];
    exp_t        mExp;
    logic        prevOk;

    ibus_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .LATENCY    (LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ireq     (ireq),
        .iresp    (iresp),
        .load_en  (load_en),
        .load_idx (load_idx),
        .load_data(load_data),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic isBad(input logic [63:0] a);
        logic [63:0] off;
        off = (a - BASE) >> 2;
        return (a < BASE) || (off >= 64'(DEPTH)) || (a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] expData(input logic [63:0] a);
        if (isBad(a)) return 32'h0;
        return modelMem[int'((a - BASE) >> 2)];
    endfunction

    task automatic pushExpected(input logic [63:0] a);
        exp_t e;
        if (isBad(a)) modelErr = 1'b1;
        e.data = expData(a);
        e.err  = modelErr;
        sbQ.push_back(e);
    endtask

    // Monitor: pops one expectation per data_ok and checks it is a single-cycle pulse.
    always @(negedge clk) begin
        if (reset && iresp.data_ok) begin
            checks++;
            if (prevOk) begin
                failures++;
                $display("[TB] FAIL data_ok_pulse: data_ok high two cycles in a row, required one cycle");
            end
            checks++;
            if (sbQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_data_ok: data=%h with no outstanding request", iresp.data);
            end else begin
                mExp = sbQ.pop_front();
                checks++;
                if (iresp.data !== mExp.data) begin
                    failures++;
                    $display("[TB] FAIL resp_data: got %h required %h", iresp.data, mExp.data);
                end
                checks++;
                if (err !== mExp.err) begin
                    failures++;
                    $display("[TB] FAIL resp_err: got %b required %b", err, mExp.err);
                end
            end
        end
        prevOk = reset && iresp.data_ok;
    end

    task automatic loadWord(input int idx, input logic [31:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_idx  = 10'(idx);
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        modelMem[idx] = d;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b0;
        modelErr = 1'b0;
        sbQ.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic issueFetch(input logic [63:0] a, output logic aok, output int lat);
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = a;
        #1;
        aok = iresp.addr_ok;
        pushExpected(a);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!iresp.data_ok && lat < 40);
        if (!iresp.data_ok) lat = -1;
        ireq.valid = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        ireq.valid = 1'b1;
        ireq.addr  = BASE;
        repeat (2) @(negedge clk);
        checks++; if (iresp.addr_ok !== 1'b0) begin failures++; $display("[TB] FAIL reset_addr_ok: got %b required 0", iresp.addr_ok); end
        checks++; if (iresp.data_ok !== 1'b0) begin failures++; $display("[TB] FAIL reset_data_ok: got %b required 0", iresp.data_ok); end
        checks++; if (iresp.data !== 32'h0) begin failures++; $display("[TB] FAIL reset_data: got %h required 0", iresp.data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b required 0", err); end
        ireq.valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic_fetch();
        logic aok;
        int   lat;
        for (int k = 0; k < 2; k++) begin
            issueFetch(BASE + 64'(4 * k), aok, lat);
            checks++; if (aok !== 1'b1) begin failures++; $display("[TB] FAIL basic_addr_ok: got %b required 1", aok); end
            checks++; if (lat < LAT || lat > LAT + MAXSTALL) begin failures++; $display("[TB] FAIL basic_latency: got %0d required %0d..%0d", lat, LAT, LAT + MAXSTALL); end
        end
    endtask

    task automatic test_error();
        logic aok;
        int   lat;
        issueFetch(64'h7FFF_FFFC, aok, lat);
        checks++; if (lat < LAT || lat > LAT + MAXSTALL) begin failures++; $display("[TB] FAIL below_base_latency: got %0d", lat); end
        repeat (3) @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL err_sticky: got %b required 1", err); end
        pulseReset();
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL err_cleared: got %b required 0", err); end
        issueFetch(64'h8000_1000, aok, lat);
        checks++; if (lat < LAT || lat > LAT + MAXSTALL) begin failures++; $display("[TB] FAIL past_end_latency: got %0d", lat); end
        pulseReset();
        issueFetch(64'h8000_0FFC, aok, lat);
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL last_word_err: got %b required 0", err); end
        issueFetch(64'h8000_0002, aok, lat);
        checks++; if (aok !== 1'b1) begin failures++; $display("[TB] FAIL misaligned_addr_ok: got %b required 1", aok); end
        pulseReset();
    endtask

    task automatic test_addr_change();
        int cyc;
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = BASE;
        #1 pushExpected(BASE);
        @(negedge clk);
        ireq.addr = BASE + 64'd4;
        cyc = 1;
        while (!iresp.data_ok && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc < LAT || cyc > LAT + MAXSTALL) begin failures++; $display("[TB] FAIL addr_change_latency: got %0d", cyc); end
        ireq.valid = 1'b0;
    endtask

    task automatic test_load_collision();
        logic aok;
        int   lat;
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = BASE;
        #1 pushExpected(BASE);
        @(negedge clk);
        load_en   = 1'b1;
        load_idx  = 10'd0;
        load_data = 32'hDEAD_BEEF;
        @(negedge clk);
        load_en = 1'b0;
        checks++; if (iresp.data_ok !== 1'b1) begin failures++; $display("[TB] FAIL collision_data_ok: got %b required 1", iresp.data_ok); end
        ireq.valid  = 1'b0;
        modelMem[0] = 32'hDEAD_BEEF;
        issueFetch(BASE, aok, lat);
        checks++; if (lat != LAT) begin failures++; $display("[TB] FAIL after_load_latency: got %0d required %0d", lat, LAT); end
    endtask

    task automatic test_reset_mid_wait();
        logic aok;
        int   lat;
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = BASE + 64'd4;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL wait_busy: got %b required 1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (iresp.data_ok !== 1'b0) begin failures++; $display("[TB] FAIL abort_data_ok: got %b required 0", iresp.data_ok); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b required 0", busy); end
        checks++; if (iresp.data !== 32'h0) begin failures++; $display("[TB] FAIL abort_data: got %h required 0", iresp.data); end
        checks++; if (iresp.addr_ok !== 1'b0) begin failures++; $display("[TB] FAIL abort_addr_ok: got %b required 0", iresp.addr_ok); end
        modelErr = 1'b0;
        sbQ.delete();
        @(negedge clk);
        ireq.valid = 1'b0;
        reset = 1'b1;
        issueFetch(BASE + 64'd4, aok, lat);
        checks++; if (aok !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_addr_ok: got %b required 1", aok); end
        checks++; if (lat < LAT || lat > LAT + MAXSTALL) begin failures++; $display("[TB] FAIL post_reset_latency: got %0d", lat); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int lo;
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = BASE + 64'd8;
        #1 pushExpected(ireq.addr);
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!iresp.data_ok && cyc < 40);
            lo = (k == 0) ? LAT : LAT + 1;
            checks++; if (cyc < lo || cyc > lo + MAXSTALL) begin failures++; $display("[TB] FAIL b2b_spacing: req %0d got %0d required %0d..%0d", k, cyc, lo, lo + MAXSTALL); end
            if (k < 3) begin
                ireq.addr = BASE + 64'(8 + 4 * (k + 1));
                #1 pushExpected(ireq.addr);
            end
        end
        ireq.valid = 1'b0;
    endtask

    task automatic test_random_fetches();
        logic aok;
        int   lat;
        int   n;
        n = (MAXSTALL > 0) ? 200 : 20;
        for (int k = 0; k < n; k++) begin
            issueFetch(BASE + 64'(4 * $urandom_range(0, 33)), aok, lat);
            checks++; if (aok !== 1'b1) begin failures++; $display("[TB] FAIL rand_addr_ok: fetch %0d got %b", k, aok); end
            checks++; if (lat < LAT || lat > LAT + MAXSTALL) begin failures++; $display("[TB] FAIL rand_latency: fetch %0d got %0d", k, lat); end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        modelErr   = 1'b0;
        prevOk     = 1'b0;
        ireq       = '0;
        load_en    = 1'b0;
        load_idx   = '0;
        load_data  = '0;
        test_reset();
        loadWord(0, 32'h0000_0093);
        loadWord(1, 32'h0010_0113);
        for (int i = 2; i < 34; i++) loadWord(i, $urandom);
        loadWord(DEPTH - 1, 32'h1234_5678);
        test_basic_fetch();
        test_error();
        test_addr_change();
`ifndef IBUS_RAND_STALL_EN
        test_load_collision();
`endif
        test_reset_mid_wait();
        test_back_to_back();
        test_random_fetches();
        repeat (3) @(negedge clk);
        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL missing_data_ok: %0d responses outstanding, required 0", sbQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
